// File: rtl/gf_row_skewer.sv
// gf_row_skewer
// Upstream feeder for a linear chain of GF(2^GF_BIT) systolic processor elements.
// One matrix row is accepted per cycle; element j of that row leaves on lane j
// exactly j+1 cycles after the accept, together with its valid/start/finish/op tags.
// A small FSM tracks matrix boundaries. After the last row it closes the input
// while the skew pipe drains, then pulses done.
//
// Handshake: a row transfers in any cycle where in_valid and in_ready are both 1.
// in_ready depends only on the FSM state and never on in_valid. Rows presented
// while in_ready is 0 are ignored, and the lanes carry bubbles for that cycle.

module gf_row_skewer #(
    parameter int GF_BIT      = 4,
    parameter int N           = 16,
    parameter int OP_CODE_LEN = 4,
    parameter int ROWS_MAX    = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*GF_BIT-1:0]        in_row,
    input  logic                       in_first,
    input  logic                       in_last,
    input  logic [OP_CODE_LEN-1:0]     in_op,
    output logic [N*GF_BIT-1:0]        lane_data,
    output logic [N-1:0]               lane_valid,
    output logic [N-1:0]               lane_start,
    output logic [N-1:0]               lane_finish,
    output logic [N*OP_CODE_LEN-1:0]   lane_op,
    output logic                       busy,
    output logic                       done,
    output logic                       err_ovf,
    output logic [1:0]                 dbg_state
);

    // Layout of one lane slot: {data, op, start, finish, valid}
    localparam int LW      = GF_BIT + OP_CODE_LEN + 3;
    localparam int B_VALID = 0;
    localparam int B_FIN   = 1;
    localparam int B_START = 2;
    localparam int OP_LSB  = 3;
    localparam int D_LSB   = 3 + OP_CODE_LEN;

    localparam int CW = $clog2(ROWS_MAX + 1);
    localparam int DW = $clog2(N);
    localparam logic [CW-1:0] ROWS_MAX_C = CW'(ROWS_MAX);
    localparam logic [CW-1:0] ROW_ONE    = CW'(1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_row_cnt;
    logic [CW-1:0]   w_row_cnt_nxt;
    logic [DW-1:0]   r_drain_cnt;
    logic [DW-1:0]   w_drain_cnt_nxt;
    logic            r_err_ovf;
    logic            w_ovf_set;
    logic            w_ready;
    logic            w_accept;

    // The input is closed only while the skew pipe drains a finished matrix
    assign w_ready   = (r_state != S_DRAIN);
    assign w_accept  = in_valid & w_ready;
    assign in_ready  = w_ready;
    assign busy      = (r_state != S_IDLE);
    assign err_ovf   = r_err_ovf;
    assign dbg_state = r_state;

    // FSM state, row counter, drain counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= '0;
            r_drain_cnt <= '0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_cnt   <= w_row_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            if (w_ovf_set) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    // Next-state logic: matrix boundary tracking and the drain countdown
    always_comb begin
        w_state_nxt     = r_state;
        w_row_cnt_nxt   = r_row_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_ovf_set       = 1'b0;
        done            = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Rows without in_first are passed through but open no matrix
                if (w_accept && in_first) begin
                    w_row_cnt_nxt = ROW_ONE;
                    if (in_last) begin
                        w_state_nxt     = S_DRAIN;
                        w_drain_cnt_nxt = DRAIN_INIT;
                    end else begin
                        w_state_nxt = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (w_accept) begin
                    if (in_first) begin
                        // A new first row without a prior last restarts the count
                        w_row_cnt_nxt = ROW_ONE;
                    end else if (r_row_cnt == ROWS_MAX_C) begin
                        // Saturate; a non-closing row past the limit flags overflow
                        if (!in_last) begin
                            w_ovf_set = 1'b1;
                        end
                    end else begin
                        w_row_cnt_nxt = r_row_cnt + ROW_ONE;
                    end
                    if (in_last) begin
                        w_state_nxt     = S_DRAIN;
                        w_drain_cnt_nxt = DRAIN_INIT;
                    end
                end
            end
            S_DRAIN: begin
                // At zero the last row's finish tag sits in lane N-1's output register
                if (r_drain_cnt == '0) begin
                    done          = 1'b1;
                    w_state_nxt   = S_IDLE;
                    w_row_cnt_nxt = '0;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - DW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One shift chain per lane; lane j is j+1 registers deep
    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [LW-1:0] w_slot;
        logic [LW-1:0] r_chain [0:j];

        // A cycle without an accept injects an all-zero bubble so lanes never hold stale data
        assign w_slot = w_accept ? {in_row[j*GF_BIT +: GF_BIT], in_op, in_first, in_last, 1'b1}
                                 : '0;

        // Shift the slot down the lane's chain
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= j; k++) begin
                    r_chain[k] <= '0;
                end
            end else begin
                r_chain[0] <= w_slot;
                for (int k = 1; k <= j; k++) begin
                    r_chain[k] <= r_chain[k-1];
                end
            end
        end

        assign lane_data[j*GF_BIT +: GF_BIT]        = r_chain[j][D_LSB +: GF_BIT];
        assign lane_op[j*OP_CODE_LEN +: OP_CODE_LEN] = r_chain[j][OP_LSB +: OP_CODE_LEN];
        assign lane_start[j]                         = r_chain[j][B_START];
        assign lane_finish[j]                        = r_chain[j][B_FIN];
        assign lane_valid[j]                         = r_chain[j][B_VALID];
    end

endmodule
